// File: rtl/lcd_text_refresher.sv
// Frame sequencer for HD44780-class LCDs: runs the power-up command list, then
// streams a writable ROWS x COLS character buffer to the byte-level LCD controller.
module lcd_text_refresher #(
  parameter int COLS            = 16,
  parameter int ROWS            = 2,
  parameter int DELAY_CYC       = 63166,
  parameter int CLEAR_DELAY_CYC = 100000,
  parameter int AW              = $clog2(ROWS*COLS)
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_char,
  input  logic          mode,
  input  logic          refresh_req,
  output logic          busy,
  output logic          init_done,
  output logic          frame_done,
  output logic          ctrl_Start,
  output logic          ctrl_RS,
  output logic [7:0]    ctrl_DATA,
  input  logic          ctrl_Done
);

  localparam int DEPTH = ROWS * COLS;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = $clog2(COLS + 1);

  typedef enum logic [2:0] {
    INIT_ISSUE, INIT_WAIT, INIT_DELAY, FR_NEXT, ISSUE, WAIT, DELAY, IDLE
  } state_t;

  state_t        r_state, w_next;
  logic [7:0]    r_buf [DEPTH];
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [1:0]    r_initIdx;
  logic [31:0]   r_cnt;
  logic          r_pending;
  logic          r_selCmd;
  logic [AW-1:0] r_selAddr;

  logic          w_load, w_ack, w_lastCnt, w_advance, w_frameEnd, w_restart;
  logic          w_initLast, w_lastItem, w_wrOk;
  logic [31:0]   w_limit;
  logic [7:0]    w_char, w_initByte;
  logic [6:0]    w_base;
  logic [AW-1:0] w_ptrAddr;

  assign busy       = (r_state != IDLE);
  assign w_wrOk     = wr_en && (int'(wr_addr) < DEPTH);
  assign w_lastItem = (int'(r_col) == COLS) && (int'(r_row) == ROWS - 1);
  // r_col = 0 is the row's set-address slot; characters occupy r_col = 1..COLS.
  assign w_ptrAddr  = AW'(int'(r_row) * COLS + int'(r_col) - 1);
  assign w_char     = (w_wrOk && (wr_addr == r_selAddr)) ? wr_char : r_buf[r_selAddr];
  assign w_limit    = (!ctrl_RS && (ctrl_DATA == 8'h01)) ? 32'(CLEAR_DELAY_CYC - 1)
                                                         : 32'(DELAY_CYC - 1);
  assign w_lastCnt  = (r_cnt >= w_limit);

  always_comb begin
    w_initByte = 8'h38;
    case (r_initIdx)
      2'd0:    w_initByte = 8'h38;
      2'd1:    w_initByte = 8'h0C;
      2'd2:    w_initByte = 8'h01;
      default: w_initByte = 8'h06;
    endcase
    w_base = 7'h00;
    case (int'(r_row))
      0:       w_base = 7'h00;
      1:       w_base = 7'h40;
      2:       w_base = 7'h14;
      default: w_base = 7'h54;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) r_state <= INIT_ISSUE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_ack      = 1'b0;
    w_advance  = 1'b0;
    w_frameEnd = 1'b0;
    w_restart  = 1'b0;
    w_initLast = 1'b0;
    case (r_state)
      INIT_ISSUE: begin
        w_load = 1'b1;
        w_next = INIT_WAIT;
      end
      INIT_WAIT: if (ctrl_Done) begin
        w_ack  = 1'b1;
        w_next = INIT_DELAY;
      end
      INIT_DELAY: if (w_lastCnt) begin
        if (r_initIdx == 2'd3) begin
          w_initLast = 1'b1;
          w_next     = FR_NEXT;
        end else begin
          w_next = INIT_ISSUE;
        end
      end
      FR_NEXT: w_next = ISSUE;
      ISSUE: begin
        w_load = 1'b1;
        w_next = WAIT;
      end
      WAIT: if (ctrl_Done) begin
        w_ack  = 1'b1;
        w_next = DELAY;
      end
      DELAY: if (w_lastCnt) begin
        w_advance = 1'b1;
        w_next    = FR_NEXT;
        if (w_lastItem) begin
          // Mode is only consulted here, so a mid-frame change waits for the frame end.
          w_frameEnd = 1'b1;
          if (!mode || r_pending) w_restart = 1'b1;
          else                    w_next    = IDLE;
        end
      end
      IDLE: if (r_pending || !mode) begin
        w_restart = 1'b1;
        w_next    = FR_NEXT;
      end
      default: w_next = INIT_ISSUE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= 8'h20;
    end else if (w_wrOk) begin
      r_buf[wr_addr] <= wr_char;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      ctrl_Start <= 1'b0;
      ctrl_RS    <= 1'b0;
      ctrl_DATA  <= 8'h00;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
      r_initIdx  <= 2'd0;
      r_cnt      <= 32'd0;
      r_pending  <= 1'b0;
      r_selCmd   <= 1'b1;
      r_selAddr  <= '0;
    end else begin
      frame_done <= w_frameEnd;
      if (w_load) begin
        ctrl_Start <= 1'b1;
        if (r_state == INIT_ISSUE) begin
          ctrl_RS   <= 1'b0;
          ctrl_DATA <= w_initByte;
        end else if (r_selCmd) begin
          ctrl_RS   <= 1'b0;
          ctrl_DATA <= {1'b1, w_base};
        end else begin
          ctrl_RS   <= 1'b1;
          ctrl_DATA <= w_char;
        end
      end
      if (w_ack) begin
        ctrl_Start <= 1'b0;
        r_cnt      <= 32'd0;
      end else if (r_state == DELAY || r_state == INIT_DELAY) begin
        r_cnt <= r_cnt + 32'd1;
      end
      if (r_state == INIT_DELAY && w_lastCnt && !w_initLast) r_initIdx <= r_initIdx + 2'd1;
      if (w_initLast) begin
        init_done <= 1'b1;
        r_row     <= '0;
        r_col     <= '0;
      end
      if (r_state == FR_NEXT) begin
        r_selCmd  <= (r_col == '0);
        r_selAddr <= w_ptrAddr;
      end
      if (w_advance) begin
        if (int'(r_col) == COLS) begin
          r_col <= '0;
          r_row <= (int'(r_row) == ROWS - 1) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      // A request arriving on the same edge a frame starts is kept, not lost.
      if (w_restart) r_pending <= 1'b0;
      if (init_done && (refresh_req || (wr_en && mode))) r_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_text_refresher.sv
// Directed bench for lcd_text_refresher: a 2x16 instance with a 3-cycle controller
// stub covers init, frames, writes, on-demand mode and reset; a 4x20 instance covers geometry.
module tb_lcd_text_refresher;

  localparam int COLS = 16, ROWS = 2, DLY = 8, CLR = 20;
  localparam int AW   = $clog2(ROWS*COLS);
  localparam int C4 = 20, R4 = 4, D4 = 2, CL4 = 3;
  localparam int AW4  = $clog2(R4*C4);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, wr_en, mode, refresh_req;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_char;
  logic          busy, init_done, frame_done, ctrl_Start, ctrl_RS, ctrl_Done;
  logic [7:0]    ctrl_DATA;

  logic           rst4_n, wr_en4, mode4, refresh_req4;
  logic [AW4-1:0] wr_addr4;
  logic [7:0]     wr_char4;
  logic           busy4, init_done4, frame_done4, ctrl_Start4, ctrl_RS4, ctrl_Done4;
  logic [7:0]     ctrl_DATA4;

  int vectors = 0;
  int miscompares = 0;

  lcd_text_refresher #(.COLS(COLS), .ROWS(ROWS), .DELAY_CYC(DLY), .CLEAR_DELAY_CYC(CLR)) u_dut (
    .iCLK(clk), .iRST_N(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .mode(mode), .refresh_req(refresh_req), .busy(busy), .init_done(init_done),
    .frame_done(frame_done), .ctrl_Start(ctrl_Start), .ctrl_RS(ctrl_RS),
    .ctrl_DATA(ctrl_DATA), .ctrl_Done(ctrl_Done));

  lcd_text_refresher #(.COLS(C4), .ROWS(R4), .DELAY_CYC(D4), .CLEAR_DELAY_CYC(CL4)) u_dut4 (
    .iCLK(clk), .iRST_N(rst4_n), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_char(wr_char4),
    .mode(mode4), .refresh_req(refresh_req4), .busy(busy4), .init_done(init_done4),
    .frame_done(frame_done4), .ctrl_Start(ctrl_Start4), .ctrl_RS(ctrl_RS4),
    .ctrl_DATA(ctrl_DATA4), .ctrl_Done(ctrl_Done4));

  // Controller stubs: Done pulses for one cycle, three cycles after Start rises.
  logic [3:0] stubCnt, stubCnt4;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stubCnt   <= 4'd0;
      ctrl_Done <= 1'b0;
    end else begin
      ctrl_Done <= ctrl_Start && (stubCnt == 4'd2) && !ctrl_Done;
      stubCnt   <= ctrl_Start ? stubCnt + 4'd1 : 4'd0;
    end
  end
  always @(posedge clk or negedge rst4_n) begin
    if (!rst4_n) begin
      stubCnt4   <= 4'd0;
      ctrl_Done4 <= 1'b0;
    end else begin
      ctrl_Done4 <= ctrl_Start4 && (stubCnt4 == 4'd2) && !ctrl_Done4;
      stubCnt4   <= ctrl_Start4 ? stubCnt4 + 4'd1 : 4'd0;
    end
  end

  // Transfer logs: byte, RS, cycles Start was low beforehand, init_done at Start rise.
  logic [7:0] logData [1024];
  logic       logRS   [1024];
  int         logGap  [1024];
  logic       logInit [1024];
  int         nLog = 0, nFrames = 0, busyLow = 0, lowCnt = 0;
  logic       prevStart = 1'b0;

  always @(negedge clk) begin
    prevStart <= ctrl_Start;
    if (ctrl_Start && !prevStart) begin
      if (nLog < 1024) begin
        logData[nLog] <= ctrl_DATA;
        logRS[nLog]   <= ctrl_RS;
        logGap[nLog]  <= lowCnt;
        logInit[nLog] <= init_done;
      end
      nLog   <= nLog + 1;
      lowCnt <= 0;
    end else if (!ctrl_Start) begin
      lowCnt <= lowCnt + 1;
    end
    if (frame_done) nFrames <= nFrames + 1;
    if (rst_n && !busy) busyLow <= busyLow + 1;
  end

  logic [7:0] logData4 [128];
  logic       logRS4   [128];
  int         nLog4 = 0, frameEnd4 = -1;
  logic       prevStart4 = 1'b0;

  always @(negedge clk) begin
    prevStart4 <= ctrl_Start4;
    if (ctrl_Start4 && !prevStart4) begin
      if (nLog4 < 128) begin
        logData4[nLog4] <= ctrl_DATA4;
        logRS4[nLog4]   <= ctrl_RS4;
      end
      nLog4 <= nLog4 + 1;
    end
    if (frame_done4 && frameEnd4 < 0) frameEnd4 <= nLog4;
  end

  task automatic wait_log(input int n, input bit four);
    int t = 0;
    while (((four ? nLog4 : nLog) < n) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if ((four ? nLog4 : nLog) < n) begin
      vectors++; miscompares++;
      $display("[TB] FAIL wait_log: got %0d transfers, expected %0d", four ? nLog4 : nLog, n);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (ctrl_Start !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_start: got %b expected 0", ctrl_Start); end
    vectors++; if (ctrl_RS !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rs: got %b expected 0", ctrl_RS); end
    vectors++; if (ctrl_DATA !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_data: got %h expected 00", ctrl_DATA); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 1", busy); end
    vectors++; if (init_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_init_done: got %b expected 0", init_done); end
    vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    logic [7:0] expB [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
    // Start-low gap = delay count + one issue cycle (init) or + FR_NEXT + ISSUE (frame).
    int expGap [5] = '{0, DLY+1, DLY+1, CLR+1, DLY+2};
    wait_log(5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (logData[i] !== expB[i] || logRS[i] !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL init_byte%0d: got RS=%b %h expected RS=0 %h", i, logRS[i], logData[i], expB[i]);
      end
    end
    for (int i = 1; i < 5; i++) begin
      vectors++;
      if (logGap[i] != expGap[i]) begin
        miscompares++;
        $display("[TB] FAIL init_gap%0d: got %0d expected %0d", i, logGap[i], expGap[i]);
      end
    end
    vectors++; if (logInit[3] !== 1'b0) begin miscompares++; $display("[TB] FAIL init_done_early: got %b expected 0", logInit[3]); end
    vectors++; if (logInit[4] !== 1'b1) begin miscompares++; $display("[TB] FAIL init_done_rise: got %b expected 1", logInit[4]); end
  endtask

  task automatic test_default_frame();
    logic [7:0] e;
    logic       er;
    wait_log(4 + 34 + 1, 1'b0);
    for (int i = 0; i < 34; i++) begin
      er = 1'b1; e = 8'h20;
      if (i == 0)  begin er = 1'b0; e = 8'h80; end
      if (i == 17) begin er = 1'b0; e = 8'hC0; end
      vectors++;
      if (logData[4+i] !== e || logRS[4+i] !== er) begin
        miscompares++;
        $display("[TB] FAIL frame0_item%0d: got RS=%b %h expected RS=%b %h", i, logRS[4+i], logData[4+i], er, e);
      end
    end
    vectors++; if (logData[38] !== 8'h80 || logRS[38] !== 1'b0) begin miscompares++; $display("[TB] FAIL frame1_restart: got RS=%b %h expected RS=0 80", logRS[38], logData[38]); end
    vectors++; if (logGap[38] != DLY + 2) begin miscompares++; $display("[TB] FAIL frame1_gap: got %0d expected %0d", logGap[38], DLY + 2); end
    vectors++; if (nFrames != 1) begin miscompares++; $display("[TB] FAIL frame_done_pulses: got %0d expected 1", nFrames); end
    vectors++; if (busyLow != 0) begin miscompares++; $display("[TB] FAIL continuous_no_idle: got %0d idle cycles expected 0", busyLow); end
  endtask

  task automatic test_write_visibility();
    int t = 0;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(17); wr_char = 8'h41;
    @(negedge clk);
    wr_en = 1'b0;
    wait_log(38 + 34, 1'b0);
    vectors++; if (logData[38+19] !== 8'h41 || logRS[38+19] !== 1'b1) begin miscompares++; $display("[TB] FAIL write_addr17: got RS=%b %h expected RS=1 41", logRS[38+19], logData[38+19]); end
    vectors++; if (logData[38+18] !== 8'h20) begin miscompares++; $display("[TB] FAIL write_neighbour16: got %h expected 20", logData[38+18]); end
    vectors++; if (logData[38+20] !== 8'h20) begin miscompares++; $display("[TB] FAIL write_neighbour18: got %h expected 20", logData[38+20]); end
    // Frame 2 starts at log 72; addr 4 goes out as log 77. Write it in that ISSUE cycle.
    wait_log(77, 1'b0);
    while (ctrl_Start && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (DLY + 1) @(posedge clk);
    #1;
    wr_en = 1'b1; wr_addr = AW'(4); wr_char = 8'h43;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    wait_log(78, 1'b0);
    vectors++; if (logData[77] !== 8'h43 || logRS[77] !== 1'b1) begin miscompares++; $display("[TB] FAIL write_bypass: got RS=%b %h expected RS=1 43", logRS[77], logData[77]); end
  endtask

  task automatic test_on_demand();
    int t = 0;
    int k = 0;
    mode = 1'b1;
    while (busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL demand_idle: got busy=%b expected 0", busy); end
    vectors++; if (nLog != 106) begin miscompares++; $display("[TB] FAIL demand_frame_completes: got %0d transfers expected 106", nLog); end
    repeat (50) @(negedge clk);
    vectors++; if (nLog != 106 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL demand_stays_idle: got %0d transfers busy=%b expected 106 busy=0", nLog, busy); end
    @(posedge clk); #1; refresh_req = 1'b1;
    @(posedge clk); #1; refresh_req = 1'b0;
    while (k < 20) begin
      @(posedge clk); #1;
      k++;
      if (ctrl_Start) break;
    end
    vectors++; if (k != 3) begin miscompares++; $display("[TB] FAIL idle_to_start: got %0d edges expected 3", k); end
    wait_log(106 + 10, 1'b0);
    @(negedge clk); refresh_req = 1'b1;
    @(negedge clk); refresh_req = 1'b0;
    wait_log(106 + 20, 1'b0);
    @(negedge clk); refresh_req = 1'b1;
    @(negedge clk); refresh_req = 1'b0;
    t = 0;
    while (busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    repeat (50) @(negedge clk);
    vectors++; if (nLog != 174) begin miscompares++; $display("[TB] FAIL demand_one_extra: got %0d transfers expected 174", nLog); end
    vectors++; if (nFrames != 5) begin miscompares++; $display("[TB] FAIL demand_frame_count: got %0d expected 5", nFrames); end
    vectors++; if (logData[106+5] !== 8'h43) begin miscompares++; $display("[TB] FAIL bypass_stored: got %h expected 43", logData[106+5]); end
    vectors++; if (logData[140] !== 8'h80 || logRS[140] !== 1'b0) begin miscompares++; $display("[TB] FAIL extra_frame_start: got RS=%b %h expected RS=0 80", logRS[140], logData[140]); end
  endtask

  task automatic test_reset_mid_transfer();
    int t = 0;
    int base;
    mode = 1'b0;
    while (!ctrl_Start && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (ctrl_Start !== 1'b0) begin miscompares++; $display("[TB] FAIL async_start: got %b expected 0", ctrl_Start); end
    vectors++; if (ctrl_DATA !== 8'h00) begin miscompares++; $display("[TB] FAIL async_data: got %h expected 00", ctrl_DATA); end
    vectors++; if (init_done !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("[TB] FAIL async_flags: got init_done=%b busy=%b expected 0 1", init_done, busy); end
    repeat (3) @(negedge clk);
    base = nLog;
    rst_n = 1'b1;
    wait_log(base + 4 + 34, 1'b0);
    vectors++; if (logData[base] !== 8'h38 || logRS[base] !== 1'b0) begin miscompares++; $display("[TB] FAIL reinit_first: got RS=%b %h expected RS=0 38", logRS[base], logData[base]); end
    vectors++; if (logData[base+2] !== 8'h01 || logGap[base+3] != CLR + 1) begin miscompares++; $display("[TB] FAIL reinit_clear: got %h gap %0d expected 01 gap %0d", logData[base+2], logGap[base+3], CLR + 1); end
    vectors++; if (logData[base+4] !== 8'h80) begin miscompares++; $display("[TB] FAIL reinit_frame: got %h expected 80", logData[base+4]); end
    vectors++; if (logData[base+4+5] !== 8'h20) begin miscompares++; $display("[TB] FAIL buffer_cleared4: got %h expected 20", logData[base+4+5]); end
    vectors++; if (logData[base+4+19] !== 8'h20) begin miscompares++; $display("[TB] FAIL buffer_cleared17: got %h expected 20", logData[base+4+19]); end
  endtask

  task automatic test_four_row();
    logic [7:0] e;
    logic       er;
    int         r, j;
    @(negedge clk);
    rst4_n = 1'b1;
    @(negedge clk); wr_en4 = 1'b1; wr_addr4 = 7'd21;  wr_char4 = 8'h42;
    @(negedge clk); wr_addr4 = 7'd80;  wr_char4 = 8'h5A;
    @(negedge clk); wr_addr4 = 7'd127; wr_char4 = 8'h5A;
    @(negedge clk); wr_en4 = 1'b0;
    wait_log(4 + 84 + 1, 1'b1);
    for (int i = 0; i < 84; i++) begin
      r = i / 21;
      j = i % 21;
      if (j == 0) begin
        er = 1'b0;
        case (r)
          0:       e = 8'h80;
          1:       e = 8'hC0;
          2:       e = 8'h94;
          default: e = 8'hD4;
        endcase
      end else begin
        er = 1'b1;
        e  = (r * 20 + j - 1 == 21) ? 8'h42 : 8'h20;
      end
      vectors++;
      if (logData4[4+i] !== e || logRS4[4+i] !== er) begin
        miscompares++;
        $display("[TB] FAIL four_row_item%0d: got RS=%b %h expected RS=%b %h", i, logRS4[4+i], logData4[4+i], er, e);
      end
    end
    vectors++; if (frameEnd4 != 88) begin miscompares++; $display("[TB] FAIL four_row_count: got %0d expected 88", frameEnd4); end
    vectors++; if (logData4[88] !== 8'h80 || logRS4[88] !== 1'b0) begin miscompares++; $display("[TB] FAIL four_row_restart: got RS=%b %h expected RS=0 80", logRS4[88], logData4[88]); end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_char = 8'h00; mode = 1'b0; refresh_req = 1'b0;
    rst4_n = 1'b0; wr_en4 = 1'b0; wr_addr4 = '0; wr_char4 = 8'h00; mode4 = 1'b0; refresh_req4 = 1'b0;
    test_reset();
    test_init();
    test_default_frame();
    test_write_visibility();
    test_on_demand();
    test_reset_mid_transfer();
    test_four_row();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lcd_text_refresher.md
# lcd_text_refresher

Parametrised HD44780-class LCD frame sequencer that replaces fixed per-screen show sequencers. It holds a writable ROWS×COLS character buffer and runs the power-up command sequence. It then streams the buffer to the existing LCD byte controller (start/done handshake) either continuously or on demand. The block sits between core logic, which writes characters, and the LCD controller, which drives the pins.

## Interface
- COLS, 16, characters per row (1..40; 1..20 when ROWS>2)
- ROWS, 2, display rows (1..4)
- DELAY_CYC, 63166, idle cycles after each ordinary transfer
- CLEAR_DELAY_CYC, 100000, idle cycles after the clear command (0x01)
- AW, $clog2(ROWS*COLS), buffer address width

Ports:
- iCLK  in  1  single clock
- iRST_N  in  1  asynchronous active-low reset
- wr_en  in  1  buffer write strobe
- wr_addr  in  AW  linear address = row*COLS+col; writes with wr_addr ≥ ROWS*COLS are ignored
- wr_char  in  8  ASCII code to store
- mode  in  1  0 = continuous refresh, 1 = on-demand refresh
- refresh_req  in  1  single-cycle request for one frame (mode 1)
- busy  out  1  high in any state except IDLE
- init_done  out  1  high once the init sequence has completed; sticky until reset
- frame_done  out  1  one-cycle pulse after the last character of a frame
- ctrl_Start  out  1  transfer request to LCD controller
- ctrl_RS  out  1  0 = command, 1 = data
- ctrl_DATA  out  8  byte to transfer
- ctrl_Done  in  1  controller completion pulse/level

## Operation
- **Buffer reset:** every entry resets to 0x20 (space).
- **Writes:** a write lands on the next edge in any state.
- **Write bypass:** if wr_en hits the entry being latched in the same cycle, wr_char is sent in place of the stored value.
- **Init list:** 0x38, 0x0C, 0x01, 0x06, all with RS=0.
- **Frame:** for each row r, send the set-address command (RS=0, 0x80|base[r]), then COLS characters (RS=1).
  - Row bases: 0x00, 0x40, 0x14, 0x54.
  - Transfers per frame: ROWS*(COLS+1).
- **States:**
  - INIT_ISSUE, INIT_WAIT, INIT_DELAY: loop over the four init commands, then go to FR_NEXT with the row/column pointer at 0.
  - FR_NEXT: one cycle; selects the next item (address command or character).
  - ISSUE: one cycle; on its exit edge, ctrl_RS/ctrl_DATA are loaded and ctrl_Start goes to 1.
  - WAIT: holds ctrl_Start=1 and the data stable until ctrl_Done is sampled 1. On that edge ctrl_Start goes to 0 and the delay counter clears.
  - DELAY: counts 0..N-1, where N is CLEAR_DELAY_CYC for the 0x01 command and DELAY_CYC otherwise. After the last count, go to FR_NEXT or INIT_ISSUE.
  - IDLE: mode 1 only.
- **End of frame:** frame_done pulses in the cycle after the final DELAY. Then:
  - mode 0: restart at row 0.
  - mode 1: if pending is set, clear it and restart; otherwise go to IDLE.
- **pending flag:** set by refresh_req, or by wr_en while mode=1, in any state after init_done.
  - Cleared when a frame starts from it.
  - A request in the same cycle as frame_done still sets it, so exactly one more frame runs.
- **IDLE exit:** leave IDLE to FR_NEXT when pending=1 or mode=0.
- **Mode change:** a change of mode mid-frame takes effect only at end of frame.
- **ctrl_Done outside WAIT:** ignored.
- **Reset mid-operation:** asynchronous and total.
  - Outputs return to reset values immediately and the buffer returns to spaces.
  - The init sequence restarts; a controller transfer already in progress is abandoned.

## Timing
- **Reset values:** ctrl_Start=0, ctrl_RS=0, ctrl_DATA=0x00, busy=1 (state INIT_ISSUE), init_done=0, frame_done=0.
- **Cycles per transfer:** 1 (FR_NEXT) + 1 (ISSUE) + W + N, where W = cycles in WAIT ≥ 1.
- **Start to RS/DATA:** ctrl_Start and ctrl_RS/ctrl_DATA change on the same edge. ctrl_Start is never high in DELAY.
- **init_done:** rises on the edge that leaves the DELAY of the fourth init command.
- **IDLE to first transfer:** with pending set, ctrl_Start rises 2 cycles after leaving IDLE.

## Test plan
- **Init sequence:** reset release with a controller stub giving Done 3 cycles after Start, DELAY_CYC=8, CLEAR_DELAY_CYC=20 → RS=0 bytes 0x38, 0x0C, 0x01, 0x06 are sent. The gap after 0x01 is 20 cycles and the others are 8. init_done then rises.
- **Default frame:** mode 0 → bytes 0x80, sixteen 0x20 (RS=1), 0xC0, sixteen 0x20. frame_done pulses once; the next frame restarts at 0x80 with no IDLE.
- **Write visibility:** write 0x41 at address 17 before its slot → row-2 second character is 0x41. A write at address 32 leaves the frame unchanged. A same-cycle write at the slot being latched sends the new value.
- **On-demand mode:** mode 1 goes to IDLE with busy=0. A refresh_req mid-frame gives exactly one extra frame, then IDLE. Two reqs in one frame still give only one extra frame.
- **Reset mid-transfer:** assert iRST_N=0 during WAIT → ctrl_Start=0 with no clock edge. The buffer reads spaces and the init sequence repeats.
- **Four-row geometry:** ROWS=4, COLS=20 → address commands 0x80, 0xC0, 0x94, 0xD4, and 84 transfers per frame.
